hazard_stall_unit: RTL

- Upstream control stage of the RV32I forwarding path; it produces the `hazard_op` code that the ALU forward-select block consumes.
- Also owns pipeline stall and flush control:
  - load-use bubble insertion
  - data-memory wait freeze, with a timeout counter
  - deferred branch/trap flush
  - a stall-cycle performance counter
- Sits in the core top, with inputs taken from the IF/ID, ID/EX and EX/MEM pipeline registers.

---
 rtl/hazard_stall_unit_pkg.sv | 15 +
 rtl/hazard_stall_unit_hazard_detect.sv | 37 +++
 rtl/hazard_stall_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared constants for the RV32I hazard/stall control path: load opcode,
// hazard_op bit positions and the stall FSM state encoding.
package hazard_stall_unit_pkg;

   localparam logic [6:0] OPCODE_LOAD = 7'b0000011;

   localparam int HOP_RS1_BIT = 0;
   localparam int HOP_RS2_BIT = 1;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } hsu_state_e;

endpackage

// File: rtl/hazard_stall_unit_hazard_detect.sv
// Pure combinational hazard detection: MEM->EX forward selects and ID-vs-EX load-use.
// Zero latency; no state, no backpressure of its own.
module hazard_detect
   import hazard_stall_unit_pkg::*;
(
   input  logic [4:0] i_id_rs1,
   input  logic [4:0] i_id_rs2,
   input  logic       i_id_use_rs1,
   input  logic       i_id_use_rs2,
   input  logic [4:0] i_ex_rs1,
   input  logic [4:0] i_ex_rs2,
   input  logic [4:0] i_ex_rd,
   input  logic [6:0] i_ex_opcode,
   input  logic [4:0] i_mem_rd,
   input  logic       i_mem_reg_write,
   output logic [1:0] o_hazard_op,
   output logic       o_load_use
);

   logic w_mem_fwd_ok;
   logic w_ex_load_ok;

   always_comb begin
      // x0 is never a real producer, so rd = 0 can neither forward nor stall
      w_mem_fwd_ok = i_mem_reg_write & (i_mem_rd != 5'd0);
      w_ex_load_ok = (i_ex_opcode == OPCODE_LOAD) & (i_ex_rd != 5'd0);

      o_hazard_op              = 2'b00;
      o_hazard_op[HOP_RS1_BIT] = w_mem_fwd_ok & (i_mem_rd == i_ex_rs1);
      o_hazard_op[HOP_RS2_BIT] = w_mem_fwd_ok & (i_mem_rd == i_ex_rs2);

      o_load_use = w_ex_load_ok &
                   ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                    (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush control: load-use bubble, dmem wait freeze with timeout,
// deferred flush and stall-cycle counter. Outputs are combinational from state + inputs.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = 16
)(
   input  logic            clk,
   input  logic            reset,
   input  logic [4:0]      ID_rs1,
   input  logic [4:0]      ID_rs2,
   input  logic            ID_use_rs1,
   input  logic            ID_use_rs2,
   input  logic [4:0]      EX_rs1,
   input  logic [4:0]      EX_rs2,
   input  logic [4:0]      EX_rd,
   input  logic [6:0]      EX_opcode,
   input  logic [4:0]      MEM_rd,
   input  logic            MEM_reg_write,
   input  logic            dmem_req,
   input  logic            dmem_ready,
   input  logic            branch_flush,
   input  logic            trap_flush,
   output logic [1:0]      hazard_op,
   output logic            pc_stall,
   output logic            IF_ID_stall,
   output logic            ID_EX_stall,
   output logic            EX_MEM_stall,
   output logic            IF_ID_flush,
   output logic            ID_EX_flush,
   output logic            mem_timeout,
   output logic [XLEN-1:0] stall_cycles
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   hsu_state_e      r_state;
   logic [CW-1:0]   r_wait_cnt;
   logic            r_pending_flush;
   logic [XLEN-1:0] r_stall_cycles;

   logic [1:0] w_hazard_op;
   logic       w_load_use;
   logic       w_mem_wait;
   logic       w_flush_req;
   logic       w_freeze;
   logic       w_flush;
   logic       w_bubble;
   logic       w_timeout;

   hazard_detect u_detect (
      .i_id_rs1        (ID_rs1),
      .i_id_rs2        (ID_rs2),
      .i_id_use_rs1    (ID_use_rs1),
      .i_id_use_rs2    (ID_use_rs2),
      .i_ex_rs1        (EX_rs1),
      .i_ex_rs2        (EX_rs2),
      .i_ex_rd         (EX_rd),
      .i_ex_opcode     (EX_opcode),
      .i_mem_rd        (MEM_rd),
      .i_mem_reg_write (MEM_reg_write),
      .o_hazard_op     (w_hazard_op),
      .o_load_use      (w_load_use)
   );

   always_comb begin
      w_mem_wait  = dmem_req & ~dmem_ready;
      // a deferred flush merges with any fresh one into a single redirect
      w_flush_req = trap_flush | branch_flush | r_pending_flush;
      w_freeze    = 1'b0;
      w_flush     = 1'b0;
      w_bubble    = 1'b0;
      w_timeout   = 1'b0;
      if (!reset) begin
         if (r_state == ST_RUN) begin
            if (w_flush_req && !w_mem_wait) begin
               w_flush = 1'b1;
            end else if (w_mem_wait) begin
               w_freeze = 1'b1;
            end else if (w_load_use) begin
               w_bubble = 1'b1;
            end
         end else begin
            w_freeze  = ~dmem_ready;
            // the RUN cycle that entered the wait already counted as cycle one
            w_timeout = ~dmem_ready & (r_wait_cnt >= CW'(MEM_TIMEOUT - 1));
         end
      end
   end

   assign hazard_op    = reset ? 2'b00 : w_hazard_op;
   assign pc_stall     = w_freeze | w_bubble;
   assign IF_ID_stall  = w_freeze | w_bubble;
   assign ID_EX_stall  = w_freeze;
   assign EX_MEM_stall = w_freeze;
   assign IF_ID_flush  = w_flush;
   assign ID_EX_flush  = w_flush | w_bubble;
   assign mem_timeout  = w_timeout;
   assign stall_cycles = r_stall_cycles;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= ST_RUN;
         r_wait_cnt      <= '0;
         r_pending_flush <= 1'b0;
         r_stall_cycles  <= '0;
      end else begin
         if (pc_stall) begin
            r_stall_cycles <= r_stall_cycles + XLEN'(1);
         end
         if (r_state == ST_RUN) begin
            if (w_flush_req && !w_mem_wait) begin
               r_pending_flush <= 1'b0;
            end else if (w_mem_wait) begin
               r_pending_flush <= w_flush_req;
               r_wait_cnt      <= CW'(1);
               r_state         <= ST_MEM_WAIT;
            end
         end else begin
            r_pending_flush <= r_pending_flush | trap_flush | branch_flush;
            if (dmem_ready || w_timeout) begin
               r_wait_cnt <= '0;
               r_state    <= ST_RUN;
            end else if (r_wait_cnt != CW'(MEM_TIMEOUT)) begin
               r_wait_cnt <= r_wait_cnt + CW'(1);
            end
         end
      end
   end

endmodule
